// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS register write-back path.
//   REG_W / DATA_W : register-number and data widths
//   REG_ZERO       : hard-wired zero register; writes to it are dropped
//   wb_req_t       : one buffered write-back request
//   reg_match      : bypass compare that never matches register 0
package mips_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  function automatic logic reg_match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return (a == b) && (a != REG_ZERO);
  endfunction

endpackage

// File: rtl/mips_reg_writeback_if.sv
// Bus between the execute/memory stage, the write-back block and the register file.
//   in_*            : write-back request handshake (valid/ready)
//   hold            : pauses draining toward the register file
//   write_*         : register file write port (signal_reg_write is the enable pulse)
//   lookup_* / hit_*: two-port bypass query into buffered writes
//   count / empty   : occupancy status
// master drives requests and lookups; slave is the write-back block.
interface mips_reg_writeback_if #(
  parameter int unsigned AW = 2
);
  import mips_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [REG_W-1:0]  in_reg;
  logic [DATA_W-1:0] in_data;
  logic              hold;
  logic [REG_W-1:0]  write_reg;
  logic [DATA_W-1:0] write_data;
  logic              signal_reg_write;
  logic [REG_W-1:0]  lookup_reg_1;
  logic [REG_W-1:0]  lookup_reg_2;
  logic              hit_1;
  logic              hit_2;
  logic [DATA_W-1:0] hit_data_1;
  logic [DATA_W-1:0] hit_data_2;
  logic [AW:0]       count;
  logic              empty;

  modport master (
    output in_valid, in_reg, in_data, hold, lookup_reg_1, lookup_reg_2,
    input  in_ready, write_reg, write_data, signal_reg_write,
    input  hit_1, hit_2, hit_data_1, hit_data_2, count, empty
  );

  modport slave (
    input  in_valid, in_reg, in_data, hold, lookup_reg_1, lookup_reg_2,
    output in_ready, write_reg, write_data, signal_reg_write,
    output hit_1, hit_2, hit_data_1, hit_data_2, count, empty
  );

endinterface

// File: rtl/mips_wb_fifo.sv
// Write-back request FIFO with an age-ordered view of every slot for bypass search.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_push      : enqueue i_data (ignored when full)
//   i_pop       : dequeue head (ignored when empty)
//   o_head      : oldest entry
//   o_count     : number of valid entries
//   o_entries[k]: k-th oldest entry (k=0 is the head)
//   o_valid[k]  : o_entries[k] holds a live request
module mips_wb_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_push,
  input  wb_req_t     i_data,
  input  logic        i_pop,
  output wb_req_t     o_head,
  output logic [AW:0] o_count,
  output wb_req_t     o_entries [DEPTH],
  output logic [DEPTH-1:0] o_valid
);

  wb_req_t       r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  // Full/empty come from the count; pointers alone are ambiguous when equal.
  assign w_do_push = i_push && (r_count != (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: slots are only observed through o_valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      o_entries[k] = r_mem[AW'(r_rptr + AW'(k))];
      o_valid[k]   = ((AW+1)'(k) < r_count);
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/mips_reg_writeback.sv
// Write-side initiator for the MIPS register file.
// Buffers write-back requests, drains one per cycle onto the register file write port
// through a registered output stage, drops writes to register 0, and answers two bypass
// lookups with the youngest pending write to the queried register.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mips_reg_writeback_if slave (request, hold, write port, lookup, status)
module mips_reg_writeback
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mips_reg_writeback_if.slave  bus
);

  localparam int unsigned NUM_LOOKUP = 2;

  wb_req_t          w_in_req;
  wb_req_t          w_head;
  wb_req_t          w_entries [DEPTH];
  logic [DEPTH-1:0] w_valid;
  logic [AW:0]      w_count;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;

  logic              r_wr_en;
  logic [REG_W-1:0]  r_wr_reg;
  logic [DATA_W-1:0] r_wr_data;

  logic [REG_W-1:0]  w_lookup   [NUM_LOOKUP];
  logic              w_hit      [NUM_LOOKUP];
  logic [DATA_W-1:0] w_hit_data [NUM_LOOKUP];

  // No pass-through when full, even if a pop happens this cycle.
  assign bus.in_ready = rst_n && (w_count < (AW+1)'(DEPTH));
  assign w_accept     = bus.in_valid && bus.in_ready;
  // Register 0 completes the handshake but is never stored.
  assign w_push       = w_accept && (bus.in_reg != REG_ZERO);
  assign w_pop        = !bus.hold && (w_count != '0);

  assign w_in_req.wreg = bus.in_reg;
  assign w_in_req.data = bus.in_data;

  mips_wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_push    (w_push),
    .i_data    (w_in_req),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_count   (w_count),
    .o_entries (w_entries),
    .o_valid   (w_valid)
  );

  // Output stage: address/data hold their last value between pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en   <= 1'b0;
      r_wr_reg  <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_pop;
      if (w_pop) begin
        r_wr_reg  <= w_head.wreg;
        r_wr_data <= w_head.data;
      end
    end
  end

  assign w_lookup[0] = bus.lookup_reg_1;
  assign w_lookup[1] = bus.lookup_reg_2;

  // Scan oldest to youngest so the last match (the youngest write) wins:
  // output stage first, then FIFO entries from head to tail.
  always_comb begin
    for (int unsigned p = 0; p < NUM_LOOKUP; p++) begin
      w_hit[p]      = 1'b0;
      w_hit_data[p] = '0;
      if (r_wr_en && reg_match(w_lookup[p], r_wr_reg)) begin
        w_hit[p]      = 1'b1;
        w_hit_data[p] = r_wr_data;
      end
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (w_valid[k] && reg_match(w_lookup[p], w_entries[k].wreg)) begin
          w_hit[p]      = 1'b1;
          w_hit_data[p] = w_entries[k].data;
        end
      end
    end
  end

  assign bus.write_reg        = r_wr_reg;
  assign bus.write_data       = r_wr_data;
  assign bus.signal_reg_write = r_wr_en;
  assign bus.hit_1            = w_hit[0];
  assign bus.hit_2            = w_hit[1];
  assign bus.hit_data_1       = w_hit_data[0];
  assign bus.hit_data_2       = w_hit_data[1];
  assign bus.count            = w_count;
  assign bus.empty            = (w_count == '0) && !r_wr_en;

endmodule

// File: tb/tb_mips_reg_writeback.sv
module tb_mips_reg_writeback;
  import mips_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  mips_reg_writeback_if #(.AW(AW)) bus ();

  mips_reg_writeback #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: a queue of pending writes plus the write currently on the port.
  wb_req_t           m_q [$];
  bit                m_pulse = 1'b0;
  logic [REG_W-1:0]  m_reg   = '0;
  logic [DATA_W-1:0] m_data  = '0;
  bit                m_acc;
  bit                m_pop;
  wb_req_t           m_req;
  logic [REG_W-1:0]  seen [$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_pulse = 1'b0;
      m_reg   = '0;
      m_data  = '0;
    end else begin
      m_acc   = bus.in_valid && (m_q.size() < DEPTH);
      m_pop   = !bus.hold && (m_q.size() > 0);
      m_pulse = m_pop;
      if (m_pop) begin
        m_req  = m_q.pop_front();
        m_reg  = m_req.wreg;
        m_data = m_req.data;
      end
      if (m_acc && bus.in_reg != 5'd0) m_q.push_back('{wreg: bus.in_reg, data: bus.in_data});
    end
  end

  function automatic void model_lookup(input logic [REG_W-1:0] r, output bit h,
                                       output logic [DATA_W-1:0] d);
    h = 1'b0;
    d = '0;
    if (r == 5'd0) return;
    for (int i = m_q.size() - 1; i >= 0; i--) begin
      if (m_q[i].wreg == r) begin
        h = 1'b1;
        d = m_q[i].data;
        return;
      end
    end
    if (m_pulse && m_reg == r) begin
      h = 1'b1;
      d = m_data;
    end
  endfunction

  task automatic compare_all();
    bit                h;
    logic [DATA_W-1:0] d;
    chk("cyc in_ready", 64'(bus.in_ready), 64'(rst_n && (m_q.size() < DEPTH)));
    chk("cyc count", 64'(bus.count), 64'(m_q.size()));
    chk("cyc signal_reg_write", 64'(bus.signal_reg_write), 64'(m_pulse));
    chk("cyc write_reg", 64'(bus.write_reg), 64'(m_reg));
    chk("cyc write_data", 64'(bus.write_data), 64'(m_data));
    chk("cyc empty", 64'(bus.empty), 64'((m_q.size() == 0) && !m_pulse));
    model_lookup(bus.lookup_reg_1, h, d);
    chk("cyc hit_1", 64'(bus.hit_1), 64'(h));
    chk("cyc hit_data_1", 64'(bus.hit_data_1), 64'(d));
    model_lookup(bus.lookup_reg_2, h, d);
    chk("cyc hit_2", 64'(bus.hit_2), 64'(h));
    chk("cyc hit_data_2", 64'(bus.hit_data_2), 64'(d));
    if (bus.signal_reg_write) seen.push_back(bus.write_reg);
  endtask

  always @(posedge clk) begin
    #1;
    compare_all();
  end

  // One request: driven on the falling edge, held across one rising edge.
  task automatic push(input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d, output bit acc);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_reg   = r;
    bus.in_data  = d;
    #1 acc = bus.in_ready;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  bit acc;

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_reg       = '0;
    bus.in_data      = '0;
    bus.hold         = 1'b0;
    bus.lookup_reg_1 = '0;
    bus.lookup_reg_2 = '0;

    #1 rst_n = 1'b0;
    #1;
    chk("reset in_ready", 64'(bus.in_ready), 64'd0);
    chk("reset signal_reg_write", 64'(bus.signal_reg_write), 64'd0);
    chk("reset count", 64'(bus.count), 64'd0);
    chk("reset write_reg", 64'(bus.write_reg), 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("post-reset in_ready", 64'(bus.in_ready), 64'd1);
    chk("post-reset empty", 64'(bus.empty), 64'd1);

    // Single write: pulse one cycle after the accepting edge's successor.
    push(5'd3, 32'h1111_1111, acc);
    chk("t1 accepted", 64'(acc), 64'd1);
    chk("t1 no pulse yet", 64'(bus.signal_reg_write), 64'd0);
    @(posedge clk); #1;
    chk("t1 pulse", 64'(bus.signal_reg_write), 64'd1);
    chk("t1 write_reg", 64'(bus.write_reg), 64'd3);
    chk("t1 write_data", 64'(bus.write_data), 64'h1111_1111);
    @(posedge clk); #1;
    chk("t1 single pulse", 64'(bus.signal_reg_write), 64'd0);
    chk("t1 empty", 64'(bus.empty), 64'd1);

    // Fill under hold, then drain in order.
    @(negedge clk) bus.hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      push(5'(i), 32'hA0 + 32'(i), acc);
      chk("t2 accepted", 64'(acc), 64'd1);
    end
    chk("t2 count full", 64'(bus.count), 64'd4);
    chk("t2 in_ready full", 64'(bus.in_ready), 64'd0);
    push(5'd5, 32'hA5, acc);
    chk("t2 fifth refused", 64'(acc), 64'd0);
    chk("t2 count still full", 64'(bus.count), 64'd4);
    @(negedge clk) bus.hold = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      chk("t2 drain pulse", 64'(bus.signal_reg_write), 64'd1);
      chk("t2 drain reg", 64'(bus.write_reg), 64'(i));
      chk("t2 drain data", 64'(bus.write_data), 64'hA0 + 64'(i));
    end
    chk("t2 count drained", 64'(bus.count), 64'd0);

    // Register 0: handshake completes, nothing stored.
    push(5'd0, 32'hDEAD_BEEF, acc);
    chk("t3 accepted", 64'(acc), 64'd1);
    chk("t3 count", 64'(bus.count), 64'd0);
    chk("t3 hit_1 reg0", 64'(bus.hit_1), 64'd0);
    @(posedge clk); #1;
    chk("t3 no pulse", 64'(bus.signal_reg_write), 64'd0);

    // Bypass: youngest duplicate wins, miss returns zero.
    @(negedge clk) bus.hold = 1'b1;
    push(5'd5, 32'h10, acc);
    push(5'd5, 32'h20, acc);
    bus.lookup_reg_1 = 5'd5;
    bus.lookup_reg_2 = 5'd6;
    #1;
    chk("t4 hit_1", 64'(bus.hit_1), 64'd1);
    chk("t4 hit_data_1", 64'(bus.hit_data_1), 64'h20);
    chk("t4 hit_2", 64'(bus.hit_2), 64'd0);
    chk("t4 hit_data_2", 64'(bus.hit_data_2), 64'd0);
    @(negedge clk) begin
      bus.hold         = 1'b0;
      bus.lookup_reg_2 = 5'd3;
    end
    repeat (4) @(posedge clk);

    // Back-to-back stream across pointer wrap.
    @(negedge clk) seen.delete();
    for (int i = 0; i < 10; i++) begin
      push(5'd10 + 5'(i), 32'h100 + 32'(i), acc);
      chk("t5 accepted", 64'(acc), 64'd1);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t5 pulse count", 64'(seen.size()), 64'd10);
    for (int i = 0; i < 10 && i < seen.size(); i++) chk("t5 order", 64'(seen[i]), 64'(10 + i));

    // Reset mid-operation drops the in-flight pulse and all buffered entries.
    @(negedge clk) bus.hold = 1'b1;
    push(5'd7, 32'h7, acc);
    push(5'd8, 32'h8, acc);
    push(5'd9, 32'h9, acc);
    chk("t6 count 3", 64'(bus.count), 64'd3);
    @(negedge clk) bus.hold = 1'b0;
    @(posedge clk); #1;
    chk("t6 pulse before reset", 64'(bus.signal_reg_write), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6 pulse dropped", 64'(bus.signal_reg_write), 64'd0);
    chk("t6 count cleared", 64'(bus.count), 64'd0);
    chk("t6 in_ready low", 64'(bus.in_ready), 64'd0);
    seen.delete();
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("t6 no stale writes", 64'(seen.size()), 64'd0);
    chk("t6 empty", 64'(bus.empty), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_reg_writeback.md
Name: mips_reg_writeback

Overview:
Write-side initiator for the MIPS register file. It accepts register write-back requests from the execute/memory stage over a valid/ready handshake and buffers them in a small FIFO. It drains one write per cycle onto the register file's write port (write_reg / write_data / signal_reg_write). It also provides a two-port bypass lookup, so readers see buffered data that has not yet been written to the file.

Parameters:
DEPTH, 4, number of buffered write requests (power of two, >=2)
AW, 2, log2(DEPTH); width of the FIFO pointers

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  write-back request present
in_ready  output  1  block can accept a request this cycle
in_reg  input  5  destination register number
in_data  input  32  value to write
hold  input  1  pauses draining; the current output stays valid-low
write_reg  output  5  register file write address
write_data  output  32  register file write data
signal_reg_write  output  1  register file write enable, one-cycle pulse per entry
lookup_reg_1  input  5  bypass query address, read port 1
lookup_reg_2  input  5  bypass query address, read port 2
hit_1  output  1  a pending write to lookup_reg_1 exists
hit_2  output  1  a pending write to lookup_reg_2 exists
hit_data_1  output  32  data of the youngest pending write to lookup_reg_1
hit_data_2  output  32  data of the youngest pending write to lookup_reg_2
count  output  AW+1  number of entries currently in the FIFO
empty  output  1  FIFO empty and no write on the port

Behaviour:
- Reset (rst_n low, asynchronous):
  - FIFO pointers and count are 0.
  - write_reg, write_data and signal_reg_write are 0.
  - in_ready is forced 0 while rst_n is low; no request is accepted during reset.
  - hit_1 and hit_2 are 0.
- Accept:
  - A request is accepted on a rising edge with in_valid && in_ready.
  - in_ready = rst_n && (count < DEPTH).
  - There is no pass-through when the FIFO is full, even if a dequeue happens in the same cycle.
- Register $0:
  - A request with in_reg==0 is accepted (the handshake completes) but is discarded and not enqueued.
  - Lookups of register 0 always return hit=0 and hit_data=0.
- Drain (registered output stage):
  - Each cycle with hold==0 and count>0, the oldest entry is popped into the output register and signal_reg_write is set to 1 for that cycle.
  - Otherwise signal_reg_write is 0.
  - write_reg and write_data hold their last value while signal_reg_write==0.
- Latency:
  - A request accepted at edge N, with the FIFO empty and hold low, is presented with signal_reg_write=1 in the cycle after edge N+1.
  - Sustained throughput is one write per cycle.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- Pointer wrap: pointers increment modulo DEPTH. Full vs empty is decided by count, not by pointer equality.
- hold:
  - While hold is high, no pop occurs, signal_reg_write is 0, and accepts continue until the FIFO is full.
  - hold never truncates a pulse already presented.
- Bypass (combinational from the lookup inputs and state):
  - The candidate set is all valid FIFO entries plus the output-stage entry while signal_reg_write==1.
  - The youngest matching entry wins, in this order: newest FIFO entry, then older FIFO entries, then the output stage.
  - hit_data is 0 when there is no hit.
- Ordering: writes reach the file in acceptance order; a duplicate destination is written in order, so the last write wins.
- empty = (count==0) && !signal_reg_write.
- Reset mid-operation: all buffered entries are discarded, and any in-flight pulse drops immediately (asynchronously).

Decomposition:
- Shared package mips_pkg:
  - REG_W=5 and DATA_W=32.
  - Constant REG_ZERO=5'd0.
  - A wb_req struct type {reg[4:0], data[31:0]}.
- One natural sub-module: mips_wb_fifo. It holds the storage array, pointers and count, and exposes all entries plus per-entry valid flags for the bypass search.
- The top level holds the output stage, the $0 filter and the priority match.

Test Plan:
- Reset, then push (3, 0x11111111) with hold=0 -> signal_reg_write=1 with write_reg=3 and write_data=0x11111111, 2 cycles after acceptance; one pulse only; empty=1 afterwards.
- hold=1, push 4 requests (regs 1..4, data 0xA1..0xA4) -> count=4, in_ready=0, and a 5th push is not accepted. Release hold -> 4 consecutive pulses in order 1,2,3,4; count returns to 0.
- Push (0, 0xDEADBEEF) -> in_ready handshake completes, count stays 0, no pulse. lookup_reg_1=0 -> hit_1=0.
- hold=1, push (5, 0x10) then (5, 0x20); lookup_reg_1=5 -> hit_1=1 and hit_data_1=0x20. lookup_reg_2=6 -> hit_2=0 and hit_data_2=0.
- Stream 10 back-to-back pushes with hold=0 -> pointers wrap past DEPTH, one pulse per cycle, no drops, acceptance order preserved.
- Fill to 3 entries, assert rst_n=0 mid-cycle -> signal_reg_write=0 and count=0 immediately, in_ready=0. After release, no stale writes appear.
